elastic_skid_fifo: RTL and testbench
====================================

Name: elastic_skid_fifo

Overview:
- Multi-entry successor to the single-register skid buffer: a DEPTH-entry circular elastic buffer on a valid/ready stream.
- Optional zero-latency bypass when empty; fill-level and almost-full outputs; synchronous flush.
- Sits between pipeline stages that need to absorb several cycles of downstream backpressure without losing data or creating a combinational ready path upstream.

Parameters:
- DWIDTH, 8, data width in bits (>=1).
- DEPTH, 4, number of storage entries (>=2; need not be a power of two).
- BYPASS, 1, 1 = data passes through combinationally when the buffer is empty (latency 0); 0 = every beat is registered (latency 1).
- AFULL_TH, DEPTH-1, o_afull asserts when the fill level is >= AFULL_TH (1..DEPTH).

Ports:
- clk  input  1  clock
- rstn  input  1  synchronous active-low reset
- i_flush  input  1  synchronous flush: discards all stored beats
- i_data  input  DWIDTH  upstream data
- i_valid  input  1  upstream data valid
- o_ready  output  1  ready to upstream
- o_data  output  DWIDTH  downstream data
- o_valid  output  1  downstream data valid
- i_ready  input  1  downstream ready
- o_count  output  $clog2(DEPTH+1)  number of beats held in storage
- o_afull  output  1  o_count >= AFULL_TH

Behaviour:
- Clock and reset:
  - Reset rstn is synchronous and active-low; clock is clk.
  - While rstn=0 the buffer resets: count=0, wr_ptr=0, rd_ptr=0, storage='0, ready_en=0.
  - Output values in reset: o_ready=0, o_valid=0, o_count=0, o_afull=0 (valid only if AFULL_TH>0, which it always is).
  - o_data in reset: BYPASS=1 gives i_data; BYPASS=0 gives 0.
  - ready_en goes to 1 on the first clock edge with rstn=1.
- Handshake:
  - Push = i_valid & o_ready.
  - Pop = o_valid & i_ready.
  - Upstream may not depend on o_ready to assert i_valid. Downstream holds no obligation.
  - o_ready = ready_en & (count != DEPTH) & !i_flush. It is a function of registers plus i_flush only, with no path from i_ready or i_valid.
- Output muxing:
  - BYPASS=1 and count==0: o_valid = i_valid & o_ready, o_data = i_data.
  - Otherwise: o_valid = (count != 0) & !i_flush, o_data = mem[rd_ptr].
- Storage update, evaluated each cycle with rstn=1 and i_flush=0:
  - Bypass beat (BYPASS=1, count==0, push & i_ready): the beat goes straight through; nothing is written and count is unchanged.
  - Push not consumed by bypass: write mem[wr_ptr] <= i_data and advance wr_ptr.
  - Pop from storage (count != 0, or BYPASS=0): advance rd_ptr.
  - count changes by +1 (store only), -1 (pop only), or 0 (both, or neither).
  - Pointers wrap from DEPTH-1 to 0 with an explicit compare; no modulo by power of two.
- Boundary conditions:
  - Full (count==DEPTH): o_ready=0. A pop in this cycle makes o_ready=1 in the next cycle, never in the same cycle.
  - Empty with BYPASS=0: o_valid=0. A push makes o_valid=1 one cycle later.
  - Simultaneous push and pop with 0<count<DEPTH: data order is preserved and count is unchanged.
- Flush:
  - i_flush=1 forces o_valid=0 and o_ready=0 combinationally, so no transfer occurs that cycle.
  - At the clock edge it sets count=0 and wr_ptr=rd_ptr=0. Storage contents are don't-care.
  - Flush has priority over push and pop. Reset has priority over flush.
- Reset mid-operation: all stored beats are lost. o_valid drops to 0 in the reset cycle; o_ready returns to 1 one cycle after rstn rises.
- Ordering: strict FIFO. No beat is duplicated or dropped except by flush or reset.
- o_count counts stored beats only; a bypassed beat never increments it. o_afull is derived combinationally from count.

Test Plan:
- Reset release, BYPASS=1, i_ready=1 -> o_ready=0 in the first cycle after rstn rises, 1 thereafter. Stream 0x01..0x0A back-to-back -> o_data equals i_data in the same cycle; o_count stays 0.
- DEPTH=4, i_ready=0, push 0xA1,0xA2,0xA3,0xA4 -> o_count goes 1,2,3,4; o_afull=1 at count 3; o_ready=0 at count 4. A 0xA5 held on i_valid is not accepted.
- From full, assert i_ready=1 for one cycle -> 0xA1 is popped, o_ready=1 on the next cycle, 0xA5 is accepted. Continued draining yields 0xA2..0xA5 in order, then o_count=0.
- BYPASS=0, i_ready=1, push 0x55 at cycle n -> o_valid=1 with o_data=0x55 at cycle n+1. Continuous streaming sustains 1 beat/cycle.
- DEPTH=3 (non-power-of-two), random i_valid/i_ready for 1000 cycles -> scoreboard shows in-order, lossless delivery; o_count never exceeds 3; pointer wrap is exercised.
- Hold 2 beats, assert i_flush for one cycle with i_valid=1 and i_ready=1 -> no transfer in that cycle; o_count=0 and o_valid=0 next cycle. A following push of 0x77 is delivered first.

Source files
------------

// File: rtl/elastic_skid_fifo.sv
// DEPTH-entry circular elastic buffer on a valid/ready stream, with optional
// zero-latency bypass when empty, fill level, almost-full and synchronous flush.
module elastic_skid_fifo #(
    parameter int DWIDTH   = 8,
    parameter int DEPTH    = 4,
    parameter int BYPASS   = 1,
    parameter int AFULL_TH = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         i_flush,
    input  logic [DWIDTH-1:0]            i_data,
    input  logic                         i_valid,
    output logic                         o_ready,
    output logic [DWIDTH-1:0]            o_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_afull
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_TH);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic          BYP_EN    = (BYPASS != 0);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              ready_en_q;

    logic push;
    logic pop;
    logic bypass_path;
    logic byp_beat;
    logic store;
    logic pop_mem;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        // Explicit wrap so non-power-of-two depths work.
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // o_ready depends only on registers and i_flush: no combinational path
    // from either handshake input.
    assign o_ready     = ready_en_q & (count_q != FULL_CNT) & ~i_flush;
    assign push        = i_valid & o_ready;
    assign bypass_path = BYP_EN & (count_q == '0);

    always_comb begin
        o_valid = 1'b0;
        o_data  = mem_q[rd_ptr_q];
        if (bypass_path) begin
            o_valid = push;
            o_data  = i_data;
        end else begin
            o_valid = (count_q != '0) & ~i_flush;
        end
    end

    assign pop      = o_valid & i_ready;
    assign byp_beat = bypass_path & push & i_ready;
    assign store    = push & ~byp_beat;
    assign pop_mem  = pop & ~bypass_path;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (store) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop_mem) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (store && !pop_mem) begin
                count_d = count_q + 1'b1;
            end else if (pop_mem && !store) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ready_en_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ready_en_q <= 1'b1;
            if (store) begin
                mem_q[wr_ptr_q] <= i_data;
            end
        end
    end

    assign o_count = count_q;
    assign o_afull = (count_q >= AFULL_CNT);

endmodule

// File: tb/tb_elastic_skid_fifo.sv
// Directed and scoreboard checks of elastic_skid_fifo in three configurations:
// DEPTH=4 bypass, DEPTH=4 registered, DEPTH=3 bypass.
module tb_elastic_skid_fifo;

    logic clk = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    // a: DEPTH=4, BYPASS=1
    logic       a_flush, a_valid, a_rdy_in, a_o_ready, a_o_valid, a_o_afull;
    logic [7:0] a_data, a_o_data;
    logic [2:0] a_o_count;
    // b: DEPTH=4, BYPASS=0
    logic       b_flush, b_valid, b_rdy_in, b_o_ready, b_o_valid, b_o_afull;
    logic [7:0] b_data, b_o_data;
    logic [2:0] b_o_count;
    // c: DEPTH=3, BYPASS=1
    logic       c_flush, c_valid, c_rdy_in, c_o_ready, c_o_valid, c_o_afull;
    logic [7:0] c_data, c_o_data;
    logic [1:0] c_o_count;

    elastic_skid_fifo #(.DWIDTH(8), .DEPTH(4), .BYPASS(1)) u_a (
        .clk(clk), .rstn(rstn), .i_flush(a_flush), .i_data(a_data), .i_valid(a_valid),
        .o_ready(a_o_ready), .o_data(a_o_data), .o_valid(a_o_valid), .i_ready(a_rdy_in),
        .o_count(a_o_count), .o_afull(a_o_afull)
    );

    elastic_skid_fifo #(.DWIDTH(8), .DEPTH(4), .BYPASS(0)) u_b (
        .clk(clk), .rstn(rstn), .i_flush(b_flush), .i_data(b_data), .i_valid(b_valid),
        .o_ready(b_o_ready), .o_data(b_o_data), .o_valid(b_o_valid), .i_ready(b_rdy_in),
        .o_count(b_o_count), .o_afull(b_o_afull)
    );

    elastic_skid_fifo #(.DWIDTH(8), .DEPTH(3), .BYPASS(1)) u_c (
        .clk(clk), .rstn(rstn), .i_flush(c_flush), .i_data(c_data), .i_valid(c_valid),
        .o_ready(c_o_ready), .o_data(c_o_data), .o_valid(c_o_valid), .i_ready(c_rdy_in),
        .o_count(c_o_count), .o_afull(c_o_afull)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled at the falling edge.
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] q [$];
    logic [7:0] prev;

    initial begin
        {a_flush, a_valid, a_rdy_in} = '0;
        {b_flush, b_valid, b_rdy_in} = '0;
        {c_flush, c_valid, c_rdy_in} = '0;
        a_data = 8'h3C;
        b_data = '0;
        c_data = '0;

        // reset values, with valid driven to show nothing passes
        a_valid  = 1'b1;
        a_rdy_in = 1'b1;
        repeat (2) nxt();
        mid();
        chk("rst_a_ready", a_o_ready, 0);
        chk("rst_a_valid", a_o_valid, 0);
        chk("rst_a_count", a_o_count, 0);
        chk("rst_a_afull", a_o_afull, 0);
        chk("rst_a_data_byp", a_o_data, 8'h3C);
        chk("rst_b_data_zero", b_o_data, 0);
        chk("rst_b_valid", b_o_valid, 0);
        nxt();
        rstn    = 1'b1;
        a_valid = 1'b0;
        mid();
        chk("rel_first_ready", a_o_ready, 0);
        chk("rel_first_b_ready", b_o_ready, 0);
        nxt();
        mid();
        chk("rel_second_ready", a_o_ready, 1);
        nxt();

        // bypass streaming 0x01..0x0A
        for (int k = 1; k <= 10; k++) begin
            a_valid = 1'b1;
            a_data  = 8'(k);
            mid();
            chk("byp_valid", a_o_valid, 1);
            chk("byp_data", a_o_data, k);
            chk("byp_count", a_o_count, 0);
            nxt();
        end
        a_valid = 1'b0;

        // fill to full with downstream stalled
        a_rdy_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1;
            a_data  = 8'hA1 + 8'(i);
            mid();
            chk("fill_count", a_o_count, i);
            chk("fill_afull", a_o_afull, (i >= 3) ? 1 : 0);
            chk("fill_ready", a_o_ready, 1);
            nxt();
        end
        a_data = 8'hA5;
        mid();
        chk("full_count", a_o_count, 4);
        chk("full_ready", a_o_ready, 0);
        chk("full_afull", a_o_afull, 1);
        chk("full_head", a_o_data, 8'hA1);
        nxt();
        mid();
        chk("full_hold_count", a_o_count, 4);
        nxt();
        a_rdy_in = 1'b1;
        mid();
        chk("pop_full_ready_same", a_o_ready, 0);
        chk("pop_full_data", a_o_data, 8'hA1);
        nxt();
        mid();
        chk("after_pop_ready", a_o_ready, 1);
        chk("after_pop_data", a_o_data, 8'hA2);
        chk("after_pop_count", a_o_count, 3);
        nxt();
        a_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            mid();
            chk("drain_data", a_o_data, 8'hA3 + 8'(j));
            chk("drain_count", a_o_count, 3 - j);
            nxt();
        end
        mid();
        chk("drained_count", a_o_count, 0);
        chk("drained_valid", a_o_valid, 0);
        nxt();

        // registered path: one cycle latency, full throughput
        b_rdy_in = 1'b1;
        b_valid  = 1'b1;
        b_data   = 8'h55;
        mid();
        chk("reg_empty_valid", b_o_valid, 0);
        prev = 8'h55;
        nxt();
        for (int j = 0; j < 8; j++) begin
            b_data = 8'h60 + 8'(j);
            mid();
            chk("reg_valid", b_o_valid, 1);
            chk("reg_data", b_o_data, prev);
            chk("reg_count", b_o_count, 1);
            chk("reg_ready", b_o_ready, 1);
            prev = b_data;
            nxt();
        end
        b_valid = 1'b0;
        mid();
        chk("reg_last_data", b_o_data, 8'h67);
        nxt();
        mid();
        chk("reg_empty_after", b_o_valid, 0);
        chk("reg_count_after", b_o_count, 0);
        nxt();

        // flush with two beats held
        b_rdy_in = 1'b0;
        b_valid  = 1'b1;
        b_data   = 8'h31;
        nxt();
        b_data = 8'h32;
        nxt();
        b_flush  = 1'b1;
        b_data   = 8'h99;
        b_rdy_in = 1'b1;
        mid();
        chk("flush_count_before", b_o_count, 2);
        chk("flush_valid", b_o_valid, 0);
        chk("flush_ready", b_o_ready, 0);
        nxt();
        b_flush = 1'b0;
        b_valid = 1'b0;
        mid();
        chk("post_flush_count", b_o_count, 0);
        chk("post_flush_valid", b_o_valid, 0);
        nxt();
        b_valid  = 1'b1;
        b_data   = 8'h77;
        b_rdy_in = 1'b0;
        nxt();
        b_valid  = 1'b0;
        b_rdy_in = 1'b1;
        mid();
        chk("post_flush_data", b_o_data, 8'h77);
        chk("post_flush_valid2", b_o_valid, 1);
        chk("post_flush_count2", b_o_count, 1);
        nxt();
        mid();
        chk("post_flush_empty", b_o_count, 0);
        nxt();

        // DEPTH=3 random traffic against a queue model
        for (int cyc = 0; cyc < 1000; cyc++) begin
            int   sz;
            logic push;
            c_valid  = ($urandom_range(0, 3) != 0);
            c_data   = 8'($urandom);
            c_rdy_in = (cyc < 500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            mid();
            sz   = q.size();
            push = c_valid && (sz != 3);
            chk("rnd_count", c_o_count, sz);
            chk("rnd_ready", c_o_ready, (sz != 3) ? 1 : 0);
            chk("rnd_valid", c_o_valid, (sz != 0 || push) ? 1 : 0);
            if (push) q.push_back(c_data);
            if (c_o_valid && c_rdy_in) begin
                if (q.size() == 0) chk("rnd_pop_empty", 1, 0);
                else chk("rnd_data", c_o_data, q.pop_front());
            end
            nxt();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
